// File: rtl/xpar_uart_tx.sv
// xpar_uart_tx: memory-mapped UART transmitter on the par_* responder bus.
// Registers (par_addr[1:0]): 0 TXDATA (W), 1 STATUS (R), 2 DIV (R/W), 3 LEVEL (R).
// Upper address bits are ignored, so the map aliases across the space.
// Optional build macro PAR_TX_PARITY_EN inserts an even-parity bit before
// the stop bit and reports itself in STATUS bit4.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | line high, waiting for a byte in the FIFO
// START  | start bit (txd=0) for DIV+1 clocks
// DATA   | 8 data bits LSB first, DIV+1 clocks each
// PARITY | even parity over the data byte (PAR_TX_PARITY_EN builds only)
// STOP   | stop bit (txd=1); last cycle chains into START if FIFO has data

module xpar_uart_tx #(
  parameter int          PAR_ADDR_W      = 12,
  parameter int          DATA_W          = 32,
  parameter int          FIFO_DEPTH_LOG2 = 3,
  parameter logic [15:0] DIV_RST         = 16'd433
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PAR_ADDR_W-1:0] par_addr,
  input  logic [DATA_W-1:0]     par_out,
  input  logic                  par_we,
  input  logic                  par_re,
  output logic [DATA_W-1:0]     par_in,
  output logic                  txd,
  output logic                  tx_idle
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2 + 1;

`ifdef PAR_TX_PARITY_EN
  localparam logic PARITY_FLAG = 1'b1;
`else
  localparam logic PARITY_FLAG = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef PAR_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] baud_q, baud_d;
  logic [15:0] reload_q, reload_d;
  logic        par_bit_q, par_bit_d;
  logic [15:0] div_q;
  logic        ovf_q;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW-1:0] level;
  logic          empty, full;
  logic [7:0]    head;

  logic sel_tx, sel_stat, sel_div;
  logic push, pop, ovf_set, ovf_clr;
  logic bit_done, busy;

  // Only the low address bits and the low half of write data are meaningful.
  logic unused_bits;
  assign unused_bits = ^{par_addr[PAR_ADDR_W-1:2], par_out[DATA_W-1:16]};

  // FIFO bookkeeping: the extra pointer MSB separates full from empty.
  assign level = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PW-1] != rptr_q[PW-1]) &&
                 (wptr_q[PW-2:0] == rptr_q[PW-2:0]);
  assign head  = mem[rptr_q[PW-2:0]];

  assign sel_tx   = (par_addr[1:0] == 2'd0);
  assign sel_stat = (par_addr[1:0] == 2'd1);
  assign sel_div  = (par_addr[1:0] == 2'd2);

  // A push into a full FIFO still fits if the shifter drains a byte this edge.
  assign push    = par_we && sel_tx && (!full || pop);
  assign ovf_set = par_we && sel_tx && full && !pop;
  assign ovf_clr = par_re && sel_stat;

  assign bit_done = (baud_q == 16'd0);
  assign busy     = (state_q != ST_IDLE);
  assign tx_idle  = empty && !busy;

  // Next-state and line-output logic for the serial shifter.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    baud_d    = baud_q;
    reload_d  = reload_q;
    par_bit_d = par_bit_q;
    pop       = 1'b0;
    txd       = 1'b1;

    case (state_q)
      ST_IDLE: begin
        txd = 1'b1;
        if (!empty) begin
          pop = 1'b1;
        end
      end

      ST_START: begin
        txd = 1'b0;
        if (bit_done) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
          baud_d    = reload_q;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end

      ST_DATA: begin
        txd = shift_q[0];
        if (bit_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          baud_d  = reload_q;
          if (bit_cnt_q == 3'd7) begin
`ifdef PAR_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end

`ifdef PAR_TX_PARITY_EN
      ST_PARITY: begin
        txd = par_bit_q;
        if (bit_done) begin
          state_d = ST_STOP;
          baud_d  = reload_q;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`endif

      ST_STOP: begin
        txd = 1'b1;
        if (bit_done) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Starting a frame: take the FIFO head and freeze the divisor for the frame.
    if (pop) begin
      state_d   = ST_START;
      shift_d   = head;
      par_bit_d = ^head;
      reload_d  = div_q;
      baud_d    = div_q;
      bit_cnt_d = 3'd0;
    end
  end

  // State, pointers and control registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= 8'd0;
      bit_cnt_q <= 3'd0;
      baud_q    <= 16'd0;
      reload_q  <= 16'd0;
      par_bit_q <= 1'b0;
      div_q     <= DIV_RST;
      ovf_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      baud_q    <= baud_d;
      reload_q  <= reload_d;
      par_bit_q <= par_bit_d;
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
      if (par_we && sel_div) begin
        div_q <= par_out[15:0];
      end
    end
  end

  // FIFO storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem[wptr_q[PW-2:0]] <= par_out[7:0];
    end
  end

  // Zero-latency read mux; driven the same way whether or not par_re is high.
  always_comb begin
    par_in = '0;
    case (par_addr[1:0])
      2'd1:    par_in[4:0]    = {PARITY_FLAG, ovf_q, empty, full, busy};
      2'd2:    par_in[15:0]   = div_q;
      2'd3:    par_in[PW-1:0] = level;
      default: par_in         = '0;
    endcase
  end

endmodule

// File: doc/xpar_uart_tx.md
Name: xpar_uart_tx

Overview:
- Responder on the external parallel interface of the Picoversat top level.
- The core initiates accesses through par_addr, par_out, par_we and par_re; this block decodes them and returns read data on par_in.
- Implements a memory-mapped UART transmitter: a TX FIFO, a programmable baud divisor, status/level registers and a serial shifter driving txd.
- Instantiated outside the core, on the par_* nets.

Parameters:
- PAR_ADDR_W, 12: width of par_addr. Only bits [1:0] are decoded; higher bits are ignored, so the register map aliases across the space.
- DATA_W, 32: width of par_out/par_in.
- FIFO_DEPTH_LOG2, 3: FIFO depth = 2**FIFO_DEPTH_LOG2 bytes (default 8).
- DIV_RST, 16'd433: reset value of the baud divisor.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- par_addr  input  PAR_ADDR_W  register address from the core.
- par_out  input  DATA_W  write data from the core.
- par_we  input  1  write strobe, single-cycle.
- par_re  input  1  read strobe, single-cycle.
- par_in  output  DATA_W  read data to the core; combinational from addr/state.
- txd  output  1  serial line, idle high.
- tx_idle  output  1  FIFO empty and FSM in IDLE.

Behaviour:
Register map, decoded on par_addr[1:0]:
- 0 TXDATA (W): push par_out[7:0] into the FIFO. Reads return 0.
- 1 STATUS (R): bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky); other bits 0. A read with par_re=1 clears overflow at that edge. A set in the same cycle wins over the clear.
- 2 DIV (R/W): 16-bit divisor in par_out[15:0]; reads zero-extend.
- 3 LEVEL (R): FIFO occupancy, 0..2**FIFO_DEPTH_LOG2, zero-extended.

Read path:
- par_in is purely combinational from par_addr and register state. The core samples it in the same cycle as par_re, so read latency is 0 cycles.
- When par_re=0, par_in is don't-care; drive the same mux output.

Write path:
- Takes effect at the edge where par_we=1.
- Push to a full FIFO is dropped and sets overflow, except when the FSM pops at the same edge. In that case the push is accepted and the level is unchanged.
- Simultaneous par_we and par_re are not issued by the core; no defined behaviour is required.

FIFO:
- Circular buffer; read/write pointers are FIFO_DEPTH_LOG2+1 bits.
- Full and empty are distinguished by the pointer MSB; pointers wrap naturally.
- Level = wptr - rptr.

FSM states: IDLE, START, DATA, STOP (plus PARITY, see Optional Feature).
- IDLE: txd=1. If the FIFO is non-empty, pop into the shift register, latch DIV into the baud counter reload, and go to START.
- Each bit lasts DIV+1 clocks. DIV=0 gives 1 clock/bit; DIV=0xFFFF gives 65536 clocks/bit.
- START: txd=0 for one bit, then DATA.
- DATA: 8 bits, LSB first, txd=shift[0]; a bit counter 0..7; then STOP.
- STOP: txd=1 for one bit. At the last cycle of STOP:
  - if the FIFO is non-empty, pop and go directly to START (no idle gap);
  - otherwise go to IDLE.
- DIV written mid-frame takes effect at the next frame only.

Latency: a TXDATA write at edge k to an empty FIFO with the FSM in IDLE gives a pop at edge k+1, with txd=0 from edge k+1.

Reset (rst=0 at an edge), including mid-frame:
- FSM to IDLE, txd=1, pointers=0, overflow=0, DIV=DIV_RST.
- The frame in progress is abandoned with no stop bit completion.
- FIFO contents are not cleared, but the FIFO is empty.

Optional Feature:
- Macro: PAR_TX_PARITY_EN.
- Defined:
  - adds a PARITY state between DATA and STOP;
  - txd = even parity (XOR of the 8 data bits) for one bit;
  - frame length is 11 bits;
  - STATUS bit4 reads 1.
- Undefined:
  - no PARITY state;
  - frame length is 10 bits;
  - STATUS bit4 reads 0.

Test Plan:
- Reset: hold rst=0 for 2 cycles, release → txd=1, STATUS=0x4, LEVEL=0, DIV reads 433, tx_idle=1.
- Single byte: DIV=3, write 0xA5 to TXDATA → txd=0 from the next edge for 4 clks, then bits 1,0,1,0,0,1,0,1 at 4 clks each, then stop=1 for 4 clks, then tx_idle=1. Frame totals 40 clks (44 with PARITY_EN; parity bit=0).
- Back-to-back: DIV=0, push 0x01,0x02,0x03 in consecutive cycles → three contiguous 10-bit frames with no idle bit between them; LEVEL reads decrement 2,1,0 as each frame starts.
- Overflow: DIV=100, push 10 bytes with the default depth → the first byte pops, 8 are queued, the 10th is dropped. STATUS reads bit1=1, bit3=1; a second STATUS read gives bit3=0.
- Full plus pop: fill the FIFO, then write exactly at the STOP→START edge → push accepted, LEVEL stays 8, overflow stays 0.
- Reset mid-frame: assert rst during DATA bit 3 → txd=1 on the next edge; LEVEL=0; the subsequent write of 0x55 transmits a correct, complete frame.
